crypto_job_scheduler: RTL and testbench

CRYPTO_JOB_SCHEDULER -- requirements
Module: crypto_job_scheduler

---
 rtl/crypto_job_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_crypto_job_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_job_scheduler.sv
// crypto_job_scheduler
//   Two-requester front end for a shared three-stage cipher datapath.
//   One job is in flight at a time. A job is accepted in IDLE, stepped
//   through ST1..ST3 with a one-hot stage strobe, and its result is held
//   in RESP until the consumer takes it.
//   Optional feature: define CRYPTO_SCHED_BURST_EN to let the last-granted
//   requester keep the grant for up to MAX_BURST consecutive jobs.
//   Without it, contention is resolved by strict round-robin.
module crypto_job_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    input  logic [5:0]  req_key0,
    input  logic [5:0]  req_key1,
    output logic [15:0] dp_data,
    output logic [5:0]  dp_key,
    output logic        dp_mode,
    output logic [2:0]  dp_stage_en,
    input  logic [15:0] dp_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [7:0]  jobs_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ST1  = 3'd1,
        ST2  = 3'd2,
        ST3  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;        // index granted most recently
    logic [15:0] dp_data_q, dp_data_d;
    logic [5:0]  dp_key_q, dp_key_d;
    logic        dp_mode_q, dp_mode_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [7:0]  jobs_done_q, jobs_done_d;

    logic        accept;                // a job transfers this cycle
    logic        grant_idx;             // requester that wins if accept is high

    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

`ifdef CRYPTO_SCHED_BURST_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // Consecutive grants already given to last_q; 0 means no grant since reset.
    logic [3:0] burst_cnt_q, burst_cnt_d;

    // Arbitration: the incumbent keeps the grant until its burst is used up.
    always_comb begin
        grant_idx   = req_valid[1];
        burst_cnt_d = burst_cnt_q;
        if (req_valid == 2'b11) begin
            if ((burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_LIMIT)) begin
                grant_idx = last_q;
            end else begin
                grant_idx = ~last_q;
            end
        end
        if (accept) begin
            if ((grant_idx == last_q) && (burst_cnt_q != 4'd0)) begin
                if (burst_cnt_q != 4'hF) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else begin
                burst_cnt_d = 4'd1;
            end
        end
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= 4'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    // Arbitration: strict round-robin, a lone requester always wins.
    always_comb begin
        grant_idx = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_idx = ~last_q;
        end
    end
`endif

    // Next-state, job latching and handshake outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        dp_data_d   = dp_data_q;
        dp_key_d    = dp_key_q;
        dp_mode_d   = dp_mode_q;
        rsp_data_d  = rsp_data_q;
        jobs_done_d = jobs_done_q;
        req_ready   = 2'b00;
        dp_stage_en = 3'b000;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready = grant_idx ? 2'b10 : 2'b01;
                    last_d    = grant_idx;
                    dp_mode_d = grant_idx;
                    dp_data_d = grant_idx ? req_data1 : req_data0;
                    dp_key_d  = grant_idx ? req_key1  : req_key0;
                    state_d   = ST1;
                end
            end
            ST1: begin
                dp_stage_en = 3'b001;
                state_d     = ST2;
            end
            ST2: begin
                dp_stage_en = 3'b010;
                state_d     = ST3;
            end
            ST3: begin
                dp_stage_en = 3'b100;
                rsp_data_d  = dp_result;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    jobs_done_d = jobs_done_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            dp_data_q   <= 16'd0;
            dp_key_q    <= 6'd0;
            dp_mode_q   <= 1'b0;
            rsp_data_q  <= 16'd0;
            jobs_done_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            dp_data_q   <= dp_data_d;
            dp_key_q    <= dp_key_d;
            dp_mode_q   <= dp_mode_d;
            rsp_data_q  <= rsp_data_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign dp_data   = dp_data_q;
    assign dp_key    = dp_key_q;
    assign dp_mode   = dp_mode_q;
    assign rsp_valid = (state_q == RESP);
    // The granted index stays latched in dp_mode_q until the next acceptance,
    // which cannot happen before the response completes.
    assign rsp_id    = dp_mode_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_crypto_job_scheduler.sv
// tb_crypto_job_scheduler
//   Directed bench for crypto_job_scheduler. The datapath is a stub whose
//   output is only meaningful while stage 3 is strobed, so a mistimed result
//   capture shows up as 16'hDEAD. Expected grant orders follow the build:
//   round-robin by default, bursts of two with CRYPTO_SCHED_BURST_EN.
module tb_crypto_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data0, req_data1;
    logic [5:0]  req_key0, req_key1;
    logic [15:0] dp_data;
    logic [5:0]  dp_key;
    logic        dp_mode;
    logic [2:0]  dp_stage_en;
    logic [15:0] dp_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        busy;
    logic [7:0]  jobs_done;

    int n_checks = 0;
    int n_errors = 0;
    int job_seq  = 0;

    always #5 clk = ~clk;

    // Cipher stub: result valid only during the stage-3 strobe.
    assign dp_result = dp_stage_en[2] ? (dp_data ^ 16'hA5A5) : 16'hDEAD;

    crypto_job_scheduler #(.MAX_BURST(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_key0    (req_key0),
        .req_key1    (req_key1),
        .dp_data     (dp_data),
        .dp_key      (dp_key),
        .dp_mode     (dp_mode),
        .dp_stage_en (dp_stage_en),
        .dp_result   (dp_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .jobs_done   (jobs_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One complete job from IDLE with rsp_ready held high; returns in IDLE.
    task automatic do_job(input logic [1:0] vld, input logic exp_id, input string tag);
        logic [15:0] exp_data;
        int          lat;
        job_seq++;
        req_data0 = 16'h1000 + 16'(job_seq);
        req_data1 = 16'h2000 + 16'(job_seq);
        exp_data  = (exp_id ? req_data1 : req_data0) ^ 16'hA5A5;
        req_valid = vld;
        rsp_ready = 1'b1;
        #1;
        check({tag, "/req_ready"}, req_ready, exp_id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        check({tag, "/dp_mode"}, dp_mode, exp_id);
        check({tag, "/dp_key"}, dp_key, exp_id ? 6'b110101 : 6'b001010);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, 4);
        check({tag, "/rsp_id"}, rsp_id, exp_id);
        check({tag, "/rsp_data"}, rsp_data, exp_data);
        @(posedge clk); #1;
        check({tag, "/idle_after"}, busy, 1'b0);
    endtask

    logic       exp_grant [6];
    logic [1:0] exp_ready_after;

    initial begin
        req_data0 = 16'h0;
        req_data1 = 16'h0;
        req_key0  = 6'b001010;
        req_key1  = 6'b110101;
`ifdef CRYPTO_SCHED_BURST_EN
        exp_grant       = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_ready_after = 2'b01;
`else
        exp_grant       = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_ready_after = 2'b10;
`endif

        // Reset state.
        do_reset();
        check("rst/busy", busy, 1'b0);
        check("rst/req_ready", req_ready, 2'b00);
        check("rst/stage_en", dp_stage_en, 3'b000);
        check("rst/rsp_valid", rsp_valid, 1'b0);
        check("rst/jobs_done", jobs_done, 8'd0);
        check("rst/dp_data", dp_data, 16'd0);
        check("rst/rsp_data", rsp_data, 16'd0);

        // Single encrypt job with stage timing, then a stalled response.
        req_data0 = 16'h1234;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1 check("j1/req_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("j1/st1", dp_stage_en, 3'b001);
        check("j1/busy", busy, 1'b1);
        check("j1/dp_data", dp_data, 16'h1234);
        check("j1/dp_key", dp_key, 6'b001010);
        check("j1/dp_mode", dp_mode, 1'b0);
        check("j1/req_ready_busy", req_ready, 2'b00);
        req_data0 = 16'hFFFF;
        @(posedge clk); #1;
        check("j1/st2", dp_stage_en, 3'b010);
        check("j1/dp_data_hold", dp_data, 16'h1234);
        @(posedge clk); #1;
        check("j1/st3", dp_stage_en, 3'b100);
        @(posedge clk); #1;
        check("j1/rsp_valid", rsp_valid, 1'b1);
        check("j1/stage_off", dp_stage_en, 3'b000);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("stall/rsp_valid", rsp_valid, 1'b1);
            check("stall/rsp_id", rsp_id, 1'b0);
            check("stall/rsp_data", rsp_data, 16'hB791);
            check("stall/req_ready", req_ready, 2'b00);
            check("stall/jobs_done", jobs_done, 8'd0);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hs/rsp_valid", rsp_valid, 1'b0);
        check("hs/jobs_done", jobs_done, 8'd1);
        check("hs/busy", busy, 1'b0);
        check("hs/next_grant", req_ready, exp_ready_after);
        req_valid = 2'b00;
        rsp_ready = 1'b0;

        // Continuous contention, then lone requesters.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_job(2'b11, exp_grant[i], $sformatf("contend%0d", i));
        end
        check("contend/jobs_done", jobs_done, 8'd6);
        do_job(2'b10, 1'b1, "solo1a");
        do_job(2'b10, 1'b1, "solo1b");
        do_job(2'b11, 1'b0, "after_solo");
        check("solo/jobs_done", jobs_done, 8'd9);

        // Reset during ST2 aborts the job.
        do_reset();
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("abort2/st2", dp_stage_en, 3'b010);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort2/stage_en", dp_stage_en, 3'b000);
        check("abort2/busy", busy, 1'b0);
        check("abort2/rsp_valid", rsp_valid, 1'b0);
        check("abort2/jobs_done", jobs_done, 8'd0);

        // Reset while the response is pending, even with rsp_ready high.
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 check("abortr/rsp_valid_pre", rsp_valid, 1'b1);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b0;
        check("abortr/rsp_valid", rsp_valid, 1'b0);
        check("abortr/jobs_done", jobs_done, 8'd0);

        // Completion counter wraps at 256 jobs.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            do_job(2'b01, 1'b0, "fill");
        end
        check("wrap/jobs_255", jobs_done, 8'd255);
        do_job(2'b01, 1'b0, "wrap_job");
        check("wrap/jobs_0", jobs_done, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
